// File: rtl/ped_xing_pkg.sv
// Shared types for the pedestrian crossing controller: phase enum and the
// per-phase lamp pattern {traff_r, traff_y, traff_g, ped_r, ped_g}.
package ped_xing_pkg;

    typedef enum logic [2:0] {
        GREEN_MIN  = 3'd0,
        GREEN_IDLE = 3'd1,
        YELLOW     = 3'd2,
        CLEAR1     = 3'd3,
        WALK       = 3'd4,
        FLASH      = 3'd5,
        CLEAR2     = 3'd6,
        NIGHT      = 3'd7
    } state_t;

    localparam int N_STATES = 8;
    localparam int STATE_W  = 3;

    typedef struct packed {
        logic traff_r;
        logic traff_y;
        logic traff_g;
        logic ped_r;
        logic ped_g;
    } lamps_t;

    // Steady pattern per phase; the flashing lamps in FLASH and NIGHT are
    // overlaid with the toggle bit in the top level.
    function automatic lamps_t lamp_enc(input state_t s);
        lamps_t l;
        case (s)
            GREEN_MIN, GREEN_IDLE: l = 5'b00110;
            YELLOW:                l = 5'b01010;
            CLEAR1, CLEAR2:        l = 5'b10010;
            WALK:                  l = 5'b10001;
            FLASH:                 l = 5'b10000;
            NIGHT:                 l = 5'b00000;
            default:               l = 5'b10010;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ped_xing_timer.sv
// Loadable down-counter advancing only on enable cycles; saturates at zero.
module ped_xing_timer #(
    parameter int               CNT_W   = 7,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (en) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ped_xing_ctrl.sv
// Button-actuated pedestrian crossing controller: phase FSM, request latch
// and flash toggle, all advancing on the 1 Hz tick enable.
module ped_xing_ctrl
    import ped_xing_pkg::*;
#(
    parameter int N_BTN       = 2,
    parameter int CNT_W       = 7,
    parameter int T_MIN_GREEN = 60,
    parameter int T_YELLOW    = 4,
    parameter int T_CLEAR     = 2,
    parameter int T_WALK      = 25,
    parameter int T_FLASH     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn,
    input  logic             night_mode,
    output logic             traff_red,
    output logic             traff_yellow,
    output logic             traff_green,
    output logic             ped_red,
    output logic             ped_green,
    output logic             ped_wait,
    output logic [CNT_W-1:0] time_left,
    output state_t           fsm_state
);

    state_t           state;
    state_t           next_state;
    logic             req;
    logic             toggle;
    logic             zero;
    logic             phase_change;
    logic [CNT_W-1:0] load_val;
    lamps_t           lamps;

    ped_xing_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(T_MIN_GREEN - 1))
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (tick),
        .load    (phase_change),
        .load_val(load_val),
        .count   (time_left),
        .zero    (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GREEN_MIN;
        end else if (tick) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            GREEN_MIN: begin
                if (zero) begin
                    if (night_mode)   next_state = NIGHT;
                    else if (req)     next_state = YELLOW;
                    else              next_state = GREEN_IDLE;
                end
            end
            GREEN_IDLE: begin
                if (night_mode)       next_state = NIGHT;
                else if (req)         next_state = YELLOW;
            end
            YELLOW:  if (zero) next_state = CLEAR1;
            CLEAR1:  if (zero) next_state = WALK;
            WALK:    if (zero) next_state = FLASH;
            FLASH:   if (zero) next_state = CLEAR2;
            CLEAR2:  if (zero) next_state = GREEN_MIN;
            NIGHT:   if (!night_mode) next_state = CLEAR2;
            default: next_state = GREEN_MIN;
        endcase
    end

    assign phase_change = (next_state != state);

    // Untimed phases (GREEN_IDLE, NIGHT) park the timer at zero.
    always_comb begin
        load_val = '0;
        case (next_state)
            GREEN_MIN: load_val = CNT_W'(T_MIN_GREEN - 1);
            YELLOW:    load_val = CNT_W'(T_YELLOW - 1);
            CLEAR1:    load_val = CNT_W'(T_CLEAR - 1);
            WALK:      load_val = CNT_W'(T_WALK - 1);
            FLASH:     load_val = CNT_W'(T_FLASH - 1);
            CLEAR2:    load_val = CNT_W'(T_CLEAR - 1);
            default:   load_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle <= 1'b1;
        end else if (tick) begin
            toggle <= phase_change ? 1'b1 : ~toggle;
        end
    end

    // Clearing on WALK entry takes priority over a press in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req <= 1'b0;
        end else if (tick && phase_change && next_state == WALK) begin
            req <= 1'b0;
        end else if ((|btn) && state != WALK && state != NIGHT) begin
            req <= 1'b1;
        end
    end

    always_comb begin
        lamps = lamp_enc(state);
        if (state == FLASH) lamps.ped_g   = toggle;
        if (state == NIGHT) lamps.traff_y = toggle;
    end

    assign traff_red    = lamps.traff_r;
    assign traff_yellow = lamps.traff_y;
    assign traff_green  = lamps.traff_g;
    assign ped_red      = lamps.ped_r;
    assign ped_green    = lamps.ped_g;
    assign ped_wait     = req;
    assign fsm_state    = state;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Randomized bench for ped_xing_ctrl against a phase/elapsed-time model.
module tb_ped_xing_ctrl;
    import ped_xing_pkg::*;

    localparam int N_BTN = 2;
    localparam int CNT_W = 7;
    localparam int TMG = 6, TY = 3, TC = 2, TW = 5, TF = 4;

    // model phase identifiers
    localparam int M_GMIN = 0, M_IDLE = 1, M_YEL = 2, M_CLR1 = 3,
                   M_WALK = 4, M_FLASH = 5, M_CLR2 = 6, M_NIGHT = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [N_BTN-1:0] btn;
    logic             night_mode;
    logic             traff_red, traff_yellow, traff_green, ped_red, ped_green;
    logic             ped_wait;
    logic [CNT_W-1:0] time_left;
    state_t           fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    int m_phase;
    int m_elapsed;
    bit m_req;

    ped_xing_ctrl #(
        .N_BTN(N_BTN), .CNT_W(CNT_W), .T_MIN_GREEN(TMG), .T_YELLOW(TY),
        .T_CLEAR(TC), .T_WALK(TW), .T_FLASH(TF)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .night_mode(night_mode),
        .traff_red(traff_red), .traff_yellow(traff_yellow),
        .traff_green(traff_green), .ped_red(ped_red), .ped_green(ped_green),
        .ped_wait(ped_wait), .time_left(time_left), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            M_GMIN:  return TMG;
            M_YEL:   return TY;
            M_CLR1:  return TC;
            M_WALK:  return TW;
            M_FLASH: return TF;
            M_CLR2:  return TC;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase   = M_GMIN;
        m_elapsed = 0;
        m_req     = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs just sampled.
    task automatic model_step();
        int  nxt;
        bit  expired;
        bit  enter_walk;
        if (rst) begin
            model_reset();
            return;
        end
        nxt        = m_phase;
        enter_walk = 1'b0;
        if (tick) begin
            expired = (dur(m_phase) > 0) && (m_elapsed == dur(m_phase) - 1);
            case (m_phase)
                M_GMIN:  if (expired) nxt = night_mode ? M_NIGHT : (m_req ? M_YEL : M_IDLE);
                M_IDLE:  nxt = night_mode ? M_NIGHT : (m_req ? M_YEL : M_IDLE);
                M_YEL:   if (expired) nxt = M_CLR1;
                M_CLR1:  if (expired) nxt = M_WALK;
                M_WALK:  if (expired) nxt = M_FLASH;
                M_FLASH: if (expired) nxt = M_CLR2;
                M_CLR2:  if (expired) nxt = M_GMIN;
                M_NIGHT: if (!night_mode) nxt = M_CLR2;
                default: nxt = M_GMIN;
            endcase
            enter_walk = (nxt == M_WALK) && (m_phase != M_WALK);
        end
        if (enter_walk)
            m_req = 1'b0;
        else if (btn != '0 && m_phase != M_WALK && m_phase != M_NIGHT)
            m_req = 1'b1;
        if (tick) begin
            if (nxt != m_phase) begin
                m_phase   = nxt;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
    endtask

    function automatic logic [4:0] exp_lamps();
        bit on = (m_elapsed % 2) == 0;
        case (m_phase)
            M_GMIN, M_IDLE: return 5'b00110;
            M_YEL:          return 5'b01010;
            M_CLR1, M_CLR2: return 5'b10010;
            M_WALK:         return 5'b10001;
            M_FLASH:        return {4'b1000, on};
            M_NIGHT:        return {1'b0, on, 3'b000};
            default:        return 5'b11111;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] exp_time();
        if (dur(m_phase) == 0) return '0;
        return CNT_W'(dur(m_phase) - 1 - m_elapsed);
    endfunction

    task automatic check_all(input string where);
        check_eq({where, "_lamps"},
                 {27'd0, traff_red, traff_yellow, traff_green, ped_red, ped_green},
                 {27'd0, exp_lamps()});
        check_eq({where, "_ped_wait"}, {31'd0, ped_wait}, {31'd0, m_req});
        check_eq({where, "_time_left"}, {25'd0, time_left}, {25'd0, exp_time()});
    endtask

    initial begin
        int tick_pct, btn_pct, night_pct;
        rst        = 1'b1;
        tick       = 1'b0;
        btn        = '0;
        night_mode = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int seg = 0; seg < 24; seg++) begin
            tick_pct  = (seg % 4 == 3) ? 60 : 100;
            case (seg % 4)
                0: btn_pct = 0;
                1: btn_pct = 3;
                2: btn_pct = 15;
                default: btn_pct = 40;
            endcase
            night_pct = (seg % 3 == 2) ? 4 : 0;
            if (night_pct == 0) night_mode = 1'b0;
            for (int cyc = 0; cyc < 120; cyc++) begin
                tick = ($urandom_range(99, 0) < tick_pct);
                btn  = ($urandom_range(99, 0) < btn_pct) ? N_BTN'($urandom_range(3, 1)) : '0;
                if ($urandom_range(99, 0) < night_pct) night_mode = ~night_mode;
                @(posedge clk);
                model_step();
                @(negedge clk);
                check_all("run");
                if (rst) begin
                    rst = 1'b0;
                end else if ($urandom_range(299, 0) == 0) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    model_reset();
                    check_all("async_rst");
                    @(negedge clk);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_xing_ctrl.md
# ped_xing_ctrl

Parametrised, button-actuated pedestrian crossing controller for one road crossing, with pedestrian request buttons on N kerbs. It sequences the traffic and pedestrian lamps through a minimum-green phase, amber, all-red clearance, walk, flashing walk and a second clearance. It adds configurable phase durations, a latched request with a "wait" indicator, a flashing pedestrian-green phase, a flashing-amber night mode and a remaining-time output. It sits between the board button inputs and the lamp drivers, and advances on a 1 Hz `tick` enable derived from the system clock rather than a divided clock.

## Interface
- `N_BTN`, 2, number of request buttons, OR-combined; ≥1
- `CNT_W`, 7, timer width; must hold max(T_*)−1
- `T_MIN_GREEN`, 60, traffic green minimum, in ticks; ≥1
- `T_YELLOW`, 4, traffic amber, ticks; ≥1
- `T_CLEAR`, 2, all-red clearance, ticks; ≥1
- `T_WALK`, 25, pedestrian steady green, ticks; ≥1
- `T_FLASH`, 5, pedestrian flashing green, ticks; ≥1
- `clk` in 1: single clock, all logic
- `rst` in 1: asynchronous, active-high reset
- `tick` in 1: one-`clk` enable pulse per second; all timing advances only on tick cycles
- `btn` in N_BTN: synchronous request buttons, level, active-high
- `night_mode` in 1: request flashing-amber mode
- `traff_red`, `traff_yellow`, `traff_green` out 1 each: traffic lamps
- `ped_red`, `ped_green` out 1 each: pedestrian lamps
- `ped_wait` out 1: request-registered indicator (= request latch)
- `time_left` out CNT_W: current timer value (ticks remaining in phase − 1)

## Operation
- States: GREEN_MIN, GREEN_IDLE, YELLOW, CLEAR1, WALK, FLASH, CLEAR2, NIGHT.
- Timer: on phase entry it loads T_phase−1 and decrements on each tick. The phase exits on a tick where timer==0, so each phase lasts exactly T_phase ticks. The timer holds 0 in GREEN_IDLE and NIGHT.
- GREEN_MIN: traff_green, ped_red. On expiry:
  - night_mode → NIGHT
  - else req → YELLOW
  - else GREEN_IDLE
- GREEN_IDLE: traff_green, ped_red. On a tick:
  - night_mode → NIGHT (priority)
  - else req → YELLOW
- YELLOW: traff_yellow, ped_red; expiry → CLEAR1.
- CLEAR1: traff_red, ped_red; expiry → WALK.
- WALK: traff_red, ped_green; expiry → FLASH.
- FLASH: traff_red, ped_red=0. ped_green is 1 at entry and toggles on every tick. Expiry → CLEAR2.
- CLEAR2: traff_red, ped_red; expiry → GREEN_MIN.
- NIGHT: traff_yellow toggles on every tick (1 at entry); traff_red, traff_green, ped_red and ped_green are all 0. On a tick with night_mode=0 → CLEAR2.
- Request latch (`req`):
  - Set on any clk cycle with |btn=1, in every state except WALK and NIGHT.
  - Cleared on the WALK entry cycle; clear wins over a simultaneous set.
  - Presses during WALK are ignored. Presses during FLASH and CLEAR2 are held for the next cycle.
- night_mode is sampled only at the decision points listed above; it never interrupts YELLOW through CLEAR2.
- Exactly one traffic lamp is lit in every state except NIGHT. ped_red and ped_green are never both 1.

## Timing
- Reset values: state GREEN_MIN, timer T_MIN_GREEN−1, req 0. Outputs: traff_green=1, all other lamps 0 except ped_red=1, ped_wait=0, time_left=T_MIN_GREEN−1.
- State, timer and toggle registers update only on clk edges where tick=1. The req latch updates on every clk edge.
- Lamps are decodes of the registered state and toggle bit, valid in the cycle after the deciding tick edge. There is no extra pipeline stage.
- ped_wait rises in the clk cycle after the btn sample.
- A request arriving in GREEN_MIN is served only after the full T_MIN_GREEN. A request in GREEN_IDLE moves to YELLOW on the next tick.
- Reset asserted mid-phase returns immediately (asynchronously) to the reset values.

## Structure
- Package `ped_xing_pkg`: state enum, state count and width, lamp-vector encoding {traff_r, traff_y, traff_g, ped_r, ped_g} per state.
- Sub-module `ped_xing_timer`: loadable CNT_W down-counter with tick enable, `load`, `load_val` and `zero` outputs.
- The top level holds the FSM, req latch and toggle register.

## Test plan
Parameters: T_MIN_GREEN=6, T_YELLOW=3, T_CLEAR=2, T_WALK=5, T_FLASH=4, tick on every clk.
- Reset, no btn for 20 ticks → GREEN_MIN for 6 ticks, then GREEN_IDLE; traff_green=1 and ped_red=1 throughout; time_left counts 5→0.
- btn[1] pulsed for 1 clk at tick 2 → ped_wait=1 next cycle. YELLOW is entered after tick 6 and lasts 3, CLEAR1 lasts 2, WALK lasts 5 with ped_wait=0, FLASH lasts 4 with ped_green 1,0,1,0, CLEAR2 lasts 2, then GREEN_MIN.
- btn held throughout WALK, released before FLASH → after CLEAR2, ped_wait=0 and the controller reaches GREEN_IDLE (presses ignored).
- btn pulse during FLASH → ped_wait stays 1. GREEN_MIN runs its full 6 ticks, then YELLOW follows directly.
- night_mode=1 in GREEN_IDLE → NIGHT with traff_yellow toggling; drop night_mode → CLEAR2 (2 ticks), then GREEN_MIN. night_mode raised during WALK → sequence completes unchanged.
- rst asserted mid-FLASH → immediate reset lamp pattern, req=0, time_left=5.
